// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler: walks the enabled ADC channels in ascending order, oversamples
// each one, and keeps the averaged results in a per-channel bank with fresh flags.
module adc_scan_scheduler #(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 12,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             cfg_mask,
  input  logic                          cfg_continuous,
  input  logic                          start,
  input  logic                          stop,
  output logic                          conv_start,
  output logic [$clog2(NUM_CH)-1:0]     conv_addr,
  input  logic                          conv_done,
  input  logic [DATA_W-1:0]             conv_data,
  input  logic [$clog2(NUM_CH)-1:0]     rd_addr,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_fresh,
  output logic                          busy,
  output logic                          scan_done,
  output logic                          timeout_err
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;

  state_t             state_reg, state_next;
  logic [CH_W-1:0]    ch_reg, ch_next;
  logic [NUM_CH-1:0]  mask_reg, mask_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [TMR_W-1:0]   timer_reg, timer_next;
  logic               stop_pending_reg, stop_pending_next;
  logic               timeout_err_reg, timeout_err_next;

  logic               store_en;
  logic               advance;
  logic               stop_now;
  logic               has_next;
  logic [CH_W-1:0]    next_ch;
  logic [CH_W-1:0]    first_ch;
  logic [ACC_W-1:0]   acc_shift;
  logic [DATA_W-1:0]  avg_value;

  logic [DATA_W-1:0]  result_mem [NUM_CH];
  logic [NUM_CH-1:0]  fresh;

  assign acc_shift   = acc_reg >> AVG_LOG2;
  assign avg_value   = acc_shift[DATA_W-1:0];
  assign stop_now    = stop_pending_reg | stop;
  assign busy        = (state_reg != IDLE);
  assign conv_addr   = (state_reg == IDLE) ? '0 : ch_reg;
  assign timeout_err = timeout_err_reg;
  assign rd_data     = result_mem[rd_addr];
  assign rd_fresh    = fresh[rd_addr];

  // Downward scans leave the lowest qualifying index as the final assignment.
  always_comb begin
    next_ch  = '0;
    has_next = 1'b0;
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_reg[i] && (CH_W'(i) > ch_reg)) begin
        next_ch  = CH_W'(i);
        has_next = 1'b1;
      end
      if (cfg_mask[i]) begin
        first_ch = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      ch_reg           <= '0;
      mask_reg         <= '0;
      acc_reg          <= '0;
      cnt_reg          <= '0;
      timer_reg        <= '0;
      stop_pending_reg <= 1'b0;
      timeout_err_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ch_reg           <= ch_next;
      mask_reg         <= mask_next;
      acc_reg          <= acc_next;
      cnt_reg          <= cnt_next;
      timer_reg        <= timer_next;
      stop_pending_reg <= stop_pending_next;
      timeout_err_reg  <= timeout_err_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    ch_next           = ch_reg;
    mask_next         = mask_reg;
    acc_next          = acc_reg;
    cnt_next          = cnt_reg;
    timer_next        = timer_reg;
    stop_pending_next = stop_pending_reg;
    timeout_err_next  = timeout_err_reg;
    store_en          = 1'b0;
    advance           = 1'b0;
    conv_start        = 1'b0;
    scan_done         = 1'b0;

    if (stop && (state_reg != IDLE)) begin
      stop_pending_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (start && (cfg_mask != '0)) begin
          mask_next        = cfg_mask;
          timeout_err_next = 1'b0;
          ch_next          = first_ch;
          state_next       = ISSUE;
        end
      end
      ISSUE: begin
        conv_start = 1'b1;
        timer_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (conv_done) begin
          if (stop_now) begin
            acc_next   = '0;
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            acc_next = acc_reg + ACC_W'(conv_data);
            if (cnt_reg == CNT_LAST) begin
              state_next = STORE;
            end else begin
              cnt_next   = cnt_reg + 1'b1;
              state_next = ISSUE;
            end
          end
        end else if (timer_reg == TMR_LAST) begin
          // A dead channel costs its partial average but not the rest of the pass.
          timeout_err_next = 1'b1;
          acc_next         = '0;
          cnt_next         = '0;
          if (stop_now) begin
            state_next = IDLE;
          end else begin
            advance = 1'b1;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      STORE: begin
        store_en = 1'b1;
        acc_next = '0;
        cnt_next = '0;
        advance  = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    if (advance) begin
      if (has_next) begin
        ch_next    = next_ch;
        state_next = ISSUE;
      end else begin
        scan_done = 1'b1;
        if (cfg_continuous && !stop_now) begin
          mask_next = cfg_mask;
          if (cfg_mask != '0) begin
            ch_next    = first_ch;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = IDLE;
        end
      end
    end

    if (state_next == IDLE) begin
      stop_pending_next = 1'b0;
    end
  end

  // Store beats a same-cycle read strobe so a brand-new result is never lost.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bank
    logic [DATA_W-1:0] value_reg;
    logic              fresh_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        value_reg <= '0;
        fresh_reg <= 1'b0;
      end else if (store_en && (ch_reg == CH_W'(gi))) begin
        value_reg <= avg_value;
        fresh_reg <= 1'b1;
      end else if (rd_en && (rd_addr == CH_W'(gi))) begin
        fresh_reg <= 1'b0;
      end
    end

    assign result_mem[gi] = value_reg;
    assign fresh[gi]      = fresh_reg;
  end

endmodule
